// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
package pc_seq_pkg;

    // Priority-encoded operation selected for the current cycle.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_RET    = 3'd1,
        OP_CALL   = 3'd2,
        OP_LOAD   = 3'd3,
        OP_BRANCH = 3'd4,
        OP_INC    = 3'd5
    } pc_op_t;

    localparam int unsigned DEF_PC_W        = 8;
    localparam int unsigned DEF_OFF_W       = 4;
    localparam int unsigned DEF_STACK_DEPTH = 4;
    localparam int unsigned DEF_RESET_VEC   = 0;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack (LIFO) for pc_sequencer.
// Pointer runs 0..STACK_DEPTH; entry storage is not reset.
// Overflow (push when full) and underflow (pop when empty) set a sticky
// error flag that only rst clears. push and pop are never both asserted.
module pc_ret_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned PC_W        = DEF_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] wdata,
    output logic [PC_W-1:0] rdata,
    output logic            empty,
    output logic            full,
    output logic            err
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(STACK_DEPTH);

    logic [PC_W-1:0]  mem_r [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [PTR_W-1:0] top_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             wr_en_s;

    // Next pointer/error computation; a dropped push or failed pop only flags.
    always_comb begin
        ptr_nxt_s = ptr_r;
        err_nxt_s = err_r;
        wr_en_s   = 1'b0;
        if (push) begin
            if (full_r) begin
                err_nxt_s = 1'b1;
            end else begin
                ptr_nxt_s = ptr_r + PTR_ONE;
                wr_en_s   = 1'b1;
            end
        end else if (pop) begin
            if (empty_r) begin
                err_nxt_s = 1'b1;
            end else begin
                ptr_nxt_s = ptr_r - PTR_ONE;
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer, status flags and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= PTR_ZERO;
            err_r   <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            ptr_r   <= ptr_nxt_s;
            err_r   <= err_nxt_s;
            empty_r <= (ptr_nxt_s == PTR_ZERO);
            full_r  <= (ptr_nxt_s == PTR_MAX);
        end
    end

    // Entry storage; written at the current pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ptr_r[IDX_W-1:0]] <= wdata;
        end
    end

    assign top_s = ptr_r - PTR_ONE;
    assign rdata = mem_r[top_s[IDX_W-1:0]];
    assign empty = empty_r;
    assign full  = full_r;
    assign err   = err_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, stall, absolute load, PC-relative
// branch and optional call/return stack. All outputs are registered.
// Optional feature macro: PC_SEQ_STACK_EN (builds the return stack; when
// undefined, call acts as load, ret is ignored, stack flags are tied off).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned OFF_W       = DEF_OFF_W,
    parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned RESET_VEC   = DEF_RESET_VEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             load,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             branch,
    input  logic [OFF_W-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  pc_out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    pc_op_t          op_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] off_ext_s;
    logic [PC_W-1:0] stk_rdata_s;
    logic            stk_empty_s;
    logic            stk_full_s;
    logic            stk_err_s;

    // Fixed-priority encoder: stall > ret > call > load > branch > increment.
    always_comb begin
        op_s = OP_INC;
        if (stall) begin
            op_s = OP_HOLD;
`ifdef PC_SEQ_STACK_EN
        end else if (ret) begin
            op_s = OP_RET;
`endif
        end else if (call) begin
            op_s = OP_CALL;
        end else if (load) begin
            op_s = OP_LOAD;
        end else if (branch) begin
            op_s = OP_BRANCH;
        end else begin
            op_s = OP_INC;
        end
    end

    // Sign-extend the branch displacement to PC width.
    always_comb begin
        off_ext_s              = {PC_W{offset[OFF_W-1]}};
        off_ext_s[OFF_W-1:0]   = offset;
    end

    assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

    // Next-PC select; all arithmetic wraps modulo 2^PC_W.
    always_comb begin
        pc_nxt_s = pc_r;
        case (op_s)
            OP_HOLD:   pc_nxt_s = pc_r;
            OP_RET:    pc_nxt_s = stk_empty_s ? pc_inc_s : stk_rdata_s;
            OP_CALL:   pc_nxt_s = pc_in;
            OP_LOAD:   pc_nxt_s = pc_in;
            OP_BRANCH: pc_nxt_s = pc_r + off_ext_s;
            OP_INC:    pc_nxt_s = pc_inc_s;
            default:   pc_nxt_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= PC_W'(RESET_VEC);
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

`ifdef PC_SEQ_STACK_EN
    logic push_s;
    logic pop_s;

    assign push_s = (op_s == OP_CALL);
    assign pop_s  = (op_s == OP_RET);

    pc_ret_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (pc_inc_s),
        .rdata (stk_rdata_s),
        .empty (stk_empty_s),
        .full  (stk_full_s),
        .err   (stk_err_s)
    );
`else
    assign stk_rdata_s = {PC_W{1'b0}};
    assign stk_empty_s = 1'b1;
    assign stk_full_s  = 1'b0;
    assign stk_err_s   = 1'b0;
`endif

    assign pc_out      = pc_r;
    assign stack_empty = stk_empty_s;
    assign stack_full  = stk_full_s;
    assign stack_err   = stk_err_s;

endmodule
